// File: rtl/map_fla_seq_pkg.sv
// Shared definitions for the mapper flash command sequencer: JEDEC command bytes,
// unlock addresses, state types and the command-table helper. Honours MAP_FLA_SEQ_ERASE_EN.
package map_fla_seq_pkg;

  localparam int unsigned ADDR_W = 23;
  localparam int unsigned DAT_W  = 8;

`ifdef MAP_FLA_SEQ_ERASE_EN
  localparam int unsigned CNT_W = 11;
`else
  localparam int unsigned CNT_W = 5;
`endif

  localparam logic [DAT_W-1:0]  CMD_AA    = 8'hAA;
  localparam logic [DAT_W-1:0]  CMD_55    = 8'h55;
  localparam logic [DAT_W-1:0]  CMD_A0    = 8'hA0;
  localparam logic [DAT_W-1:0]  CMD_80    = 8'h80;
  localparam logic [DAT_W-1:0]  CMD_30    = 8'h30;
  localparam logic [ADDR_W-1:0] UNLOCK_A1 = 23'h000555;
  localparam logic [ADDR_W-1:0] UNLOCK_A2 = 23'h0002AA;

  typedef enum logic [1:0] {SEQ_IDLE, SEQ_BUS, SEQ_WAIT} seq_state_e;
  typedef enum logic [1:0] {CYC_IDLE, CYC_SETUP, CYC_PULSE, CYC_HOLD} cyc_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DAT_W-1:0]  dat;
  } bus_word_t;

  // Down-counters run from t-1 to 0, so a zero timing parameter behaves as one cycle.
  function automatic logic [CNT_W-1:0] cnt_load(int unsigned t);
    int unsigned v;
    v = (t == 0) ? 0 : t - 1;
    return v[CNT_W-1:0];
  endfunction

  function automatic bus_word_t cmd_word(logic [2:0] idx, logic erase,
                                         logic [ADDR_W-1:0] a, logic [DAT_W-1:0] d);
    bus_word_t w;
    w = '{addr: UNLOCK_A1, dat: CMD_AA};
    case (idx)
      3'd1:    w = '{addr: UNLOCK_A2, dat: CMD_55};
      3'd2:    w = erase ? '{addr: UNLOCK_A1, dat: CMD_80} : '{addr: UNLOCK_A1, dat: CMD_A0};
      3'd3:    w = erase ? '{addr: UNLOCK_A1, dat: CMD_AA} : '{addr: a, dat: d};
      3'd4:    w = '{addr: UNLOCK_A2, dat: CMD_55};
      3'd5:    w = '{addr: a, dat: CMD_30};
      default: w = '{addr: UNLOCK_A1, dat: CMD_AA};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/map_fla_seq_if.sv
// Request/flash bus bundle between the mapper decoder and the flash sequencer.
interface map_fla_seq_if;
  import map_fla_seq_pkg::*;

  logic              req;
  logic              req_erase;
  logic [ADDR_W-1:0] req_addr;
  logic [DAT_W-1:0]  req_dat;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] fla_addr;
  logic [DAT_W-1:0]  fla_dat;
  logic              fla_ce_n;
  logic              fla_we_n;

  modport slave (
    input  req, req_erase, req_addr, req_dat,
    output busy, done, fla_addr, fla_dat, fla_ce_n, fla_we_n
  );

  modport master (
    output req, req_erase, req_addr, req_dat,
    input  busy, done, fla_addr, fla_dat, fla_ce_n, fla_we_n
  );
endinterface

// File: rtl/map_fla_seq_buscyc.sv
// Single flash bus cycle timer: SETUP / PULSE / HOLD, with a start input and a
// one-cycle finish flag on the last HOLD cycle so back-to-back cycles chain without a gap.
module map_fla_buscyc
  import map_fla_seq_pkg::*;
#(
  parameter int unsigned T_SU  = 2,
  parameter int unsigned T_WP  = 3,
  parameter int unsigned T_HLD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_start,
  output logic o_active,
  output logic o_we_n,
  output logic o_finish
);

  cyc_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= CYC_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_finish    = 1'b0;
    case (r_state)
      CYC_IDLE: begin
        if (i_start) begin
          w_state_nxt = CYC_SETUP;
          w_cnt_nxt   = cnt_load(T_SU);
        end
      end
      CYC_SETUP: begin
        if (w_cnt_zero) begin
          w_state_nxt = CYC_PULSE;
          w_cnt_nxt   = cnt_load(T_WP);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      CYC_PULSE: begin
        if (w_cnt_zero) begin
          w_state_nxt = CYC_HOLD;
          w_cnt_nxt   = cnt_load(T_HLD);
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      CYC_HOLD: begin
        if (w_cnt_zero) begin
          o_finish = 1'b1;
          if (i_start) begin
            w_state_nxt = CYC_SETUP;
            w_cnt_nxt   = cnt_load(T_SU);
          end else begin
            w_state_nxt = CYC_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = CYC_IDLE;
    endcase
  end

  assign o_active = (r_state != CYC_IDLE);
  assign o_we_n   = (r_state != CYC_PULSE);

endmodule

// File: rtl/map_fla_seq.sv
// Mapper flash command sequencer: expands a program (or, with MAP_FLA_SEQ_ERASE_EN,
// sector-erase) request into the JEDEC unlock/command bus cycles, then a busy WAIT.
module map_fla_seq
  import map_fla_seq_pkg::*;
#(
  parameter int unsigned T_SU   = 2,
  parameter int unsigned T_WP   = 3,
  parameter int unsigned T_HLD  = 2,
  parameter int unsigned T_PROG = 16,
  parameter int unsigned T_ERS  = 1024
) (
  input  logic           clk,
  input  logic           rst_n,
  map_fla_seq_if.slave   bus
);

  seq_state_e        r_state, w_state_nxt;
  logic [2:0]        r_idx, w_idx_nxt;
  logic              r_erase, w_erase_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [DAT_W-1:0]  r_dat, w_dat_nxt;
  bus_word_t         r_fla, w_fla_nxt;
  logic [CNT_W-1:0]  r_wcnt, w_wcnt_nxt;
  logic              r_done, w_done_nxt;
  logic              w_start, w_finish, w_active, w_we_n, w_req_erase, w_last;

`ifdef MAP_FLA_SEQ_ERASE_EN
  assign w_req_erase = bus.req_erase;
`else
  logic w_unused_erase;
  localparam int unsigned unused_t_ers = T_ERS;
  assign w_unused_erase = bus.req_erase;
  assign w_req_erase    = 1'b0;
`endif

  map_fla_buscyc #(
    .T_SU  (T_SU),
    .T_WP  (T_WP),
    .T_HLD (T_HLD)
  ) u_buscyc (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_start),
    .o_active (w_active),
    .o_we_n   (w_we_n),
    .o_finish (w_finish)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEQ_IDLE;
      r_idx   <= '0;
      r_erase <= 1'b0;
      r_addr  <= '0;
      r_dat   <= '0;
      r_fla   <= '0;
      r_wcnt  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_erase <= w_erase_nxt;
      r_addr  <= w_addr_nxt;
      r_dat   <= w_dat_nxt;
      r_fla   <= w_fla_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign w_last = r_erase ? (r_idx == 3'd5) : (r_idx == 3'd3);

  // The next bus word is loaded on the same edge the timer enters SETUP, so
  // address/data are stable for the whole of each bus cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_erase_nxt = r_erase;
    w_addr_nxt  = r_addr;
    w_dat_nxt   = r_dat;
    w_fla_nxt   = r_fla;
    w_wcnt_nxt  = r_wcnt;
    w_done_nxt  = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      SEQ_IDLE: begin
        if (bus.req || w_req_erase) begin
          w_state_nxt = SEQ_BUS;
          w_idx_nxt   = '0;
          w_erase_nxt = w_req_erase;
          w_addr_nxt  = bus.req_addr;
          w_dat_nxt   = bus.req_dat;
          w_fla_nxt   = cmd_word(3'd0, w_req_erase, bus.req_addr, bus.req_dat);
          w_start     = 1'b1;
        end
      end
      SEQ_BUS: begin
        if (w_finish) begin
          if (w_last) begin
            w_state_nxt = SEQ_WAIT;
`ifdef MAP_FLA_SEQ_ERASE_EN
            w_wcnt_nxt  = r_erase ? cnt_load(T_ERS) : cnt_load(T_PROG);
`else
            w_wcnt_nxt  = cnt_load(T_PROG);
`endif
          end else begin
            w_idx_nxt = r_idx + 3'd1;
            w_fla_nxt = cmd_word(r_idx + 3'd1, r_erase, r_addr, r_dat);
            w_start   = 1'b1;
          end
        end
      end
      SEQ_WAIT: begin
        if (r_wcnt == '0) begin
          w_state_nxt = SEQ_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

  assign bus.busy     = (r_state != SEQ_IDLE);
  assign bus.done     = r_done;
  assign bus.fla_addr = r_fla.addr;
  assign bus.fla_dat  = r_fla.dat;
  assign bus.fla_ce_n = ~w_active;
  assign bus.fla_we_n = w_we_n;

endmodule

// File: tb/tb_map_fla_seq.sv
// Scoreboard bench for map_fla_seq: expected flash writes are queued when a request is
// driven and popped on each WE falling edge; also checks timing, busy/done and reset.
module tb_map_fla_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  map_fla_seq_if bif();

  map_fla_seq #(
    .T_SU   (2),
    .T_WP   (3),
    .T_HLD  (2),
    .T_PROG (16),
    .T_ERS  (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int          total = 0;
  int          bad   = 0;
  logic [30:0] sb[$];
  bit          in_p  = 1'b0;
  int          plen  = 0;
  logic [30:0] p_word;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus monitor: one scoreboard entry per WE pulse; width and hold checked at pulse end.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_p = 1'b0;
    end else if (!bif.fla_we_n) begin
      if (!in_p) begin
        in_p   = 1'b1;
        plen   = 1;
        p_word = {bif.fla_addr, bif.fla_dat};
        check("ce_in_pulse", bif.fla_ce_n, 0);
        if (sb.size() == 0) begin
          check("pulse_unexpected", 1, 0);
        end else begin
          logic [30:0] e;
          e = sb.pop_front();
          check("wr_addr", bif.fla_addr, e[30:8]);
          check("wr_dat", bif.fla_dat, e[7:0]);
        end
      end else begin
        plen++;
      end
    end else if (in_p) begin
      in_p = 1'b0;
      check("we_width", plen, 3);
      check("wr_hold", {bif.fla_addr, bif.fla_dat}, p_word);
    end
  end

  task automatic push_prog(input logic [22:0] a, input logic [7:0] d);
    sb.push_back({23'h000555, 8'hAA});
    sb.push_back({23'h0002AA, 8'h55});
    sb.push_back({23'h000555, 8'hA0});
    sb.push_back({a, d});
  endtask

  task automatic push_erase(input logic [22:0] a);
    sb.push_back({23'h000555, 8'hAA});
    sb.push_back({23'h0002AA, 8'h55});
    sb.push_back({23'h000555, 8'h80});
    sb.push_back({23'h000555, 8'hAA});
    sb.push_back({23'h0002AA, 8'h55});
    sb.push_back({a, 8'h30});
  endtask

  // Request held for one edge; inputs scrambled afterwards to prove they were latched.
  task automatic issue(input bit p, input bit e, input logic [22:0] a, input logic [7:0] d);
    @(negedge clk);
    bif.req       = p;
    bif.req_erase = e;
    bif.req_addr  = a;
    bif.req_dat   = d;
    @(posedge clk);
    #1;
    bif.req       = 1'b0;
    bif.req_erase = 1'b0;
    bif.req_addr  = ~a;
    bif.req_dat   = ~d;
  endtask

  task automatic wait_done(input int exp, input int inj);
    bit seen  = 1'b0;
    int ndone = 0;
    for (int k = 1; k <= exp + 20; k++) begin
      @(negedge clk);
      if (k == inj) begin
        bif.req      = 1'b1;
        bif.req_addr = 23'h000000;
        bif.req_dat  = 8'hFF;
      end else if (k == inj + 1) begin
        bif.req = 1'b0;
      end
      if (bif.done) ndone++;
      if (k == 1) check("busy_rise", bif.busy, 1);
      if (!seen && k == exp - 1) begin
        check("busy_in_wait", bif.busy, 1);
        check("ce_in_wait", bif.fla_ce_n, 1);
      end
      if (!seen && bif.done) begin
        seen = 1'b1;
        check("done_cycle", k, exp);
        check("busy_fall", bif.busy, 0);
      end
    end
    if (!seen) check("done_seen", 0, 1);
    check("done_count", ndone, 1);
    check("sb_empty", sb.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] ra;
    logic [7:0]  rd;
    int          errs;

    bif.req       = 1'b0;
    bif.req_erase = 1'b0;
    bif.req_addr  = '0;
    bif.req_dat   = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", bif.busy, 0);
    check("rst_done", bif.done, 0);
    check("rst_ce_n", bif.fla_ce_n, 1);
    check("rst_we_n", bif.fla_we_n, 1);
    check("rst_addr", bif.fla_addr, 0);
    check("rst_dat", bif.fla_dat, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ce_n", bif.fla_ce_n, 1);

    push_prog(23'h012345, 8'h5A);
    issue(1'b1, 1'b0, 23'h012345, 8'h5A);
    wait_done(45, 0);

    push_prog(23'h7FFFFF, 8'h00);
    issue(1'b1, 1'b0, 23'h7FFFFF, 8'h00);
    wait_done(45, 0);

    for (int i = 0; i < 2; i++) begin
      ra = 23'($urandom);
      rd = 8'($urandom);
      push_prog(ra, rd);
      issue(1'b1, 1'b0, ra, rd);
      wait_done(45, 0);
    end

    // Collision: second request at cycle 10 must be dropped.
    push_prog(23'h012345, 8'h5A);
    issue(1'b1, 1'b0, 23'h012345, 8'h5A);
    wait_done(45, 10);

    // Reset inside the WE pulse of bus cycle 2.
    push_prog(23'h012345, 8'h5A);
    issue(1'b1, 1'b0, 23'h012345, 8'h5A);
    repeat (18) @(negedge clk);
    check("mid_we_low", bif.fla_we_n, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_we_n", bif.fla_we_n, 1);
    check("arst_ce_n", bif.fla_ce_n, 1);
    check("arst_busy", bif.busy, 0);
    check("arst_addr", bif.fla_addr, 0);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_prog(23'h00ABCD, 8'hC3);
    issue(1'b1, 1'b0, 23'h00ABCD, 8'hC3);
    wait_done(45, 0);

`ifdef MAP_FLA_SEQ_ERASE_EN
    push_erase(23'h040000);
    issue(1'b0, 1'b1, 23'h040000, 8'h00);
    wait_done(51, 0);

    push_erase(23'h1F0000);
    issue(1'b1, 1'b1, 23'h1F0000, 8'h77);
    wait_done(51, 0);
`else
    issue(1'b0, 1'b1, 23'h040000, 8'h00);
    errs = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bif.busy !== 1'b0 || bif.fla_ce_n !== 1'b1) errs++;
    end
    check("erase_off_idle", errs, 0);

    push_prog(23'h040000, 8'h66);
    issue(1'b1, 1'b1, 23'h040000, 8'h66);
    wait_done(45, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/map_fla_seq.md
MAP_FLA_SEQ -- requirements
Module: map_fla_seq

Interface
REQ-001 SHALL have parameters: T_SU, default 2, address/data setup cycles before WE low; T_WP, default 3, WE-low cycles; T_HLD, default 2, WE-high hold cycles after pulse; T_PROG, default 16, post-program busy cycles; T_ERS, default 1024, post-erase busy cycles.
REQ-002 SHALL have ports, one per line:
clk  in  1  system clock, sole clock.
rst_n  in  1  asynchronous active-low reset.
req  in  1  one-cycle program request from mapper flash decoder.
req_erase  in  1  one-cycle sector-erase request.
req_addr  in  23  physical flash target address (bank-resolved).
req_dat  in  8  program data.
busy  out  1  sequence in progress.
done  out  1  one-cycle completion pulse.
fla_addr  out  23  physical flash address.
fla_dat  out  8  physical flash write data.
fla_ce_n  out  1  flash chip enable, active-low.
fla_we_n  out  1  flash write enable, active-low.
REQ-003 Clock and reset SHALL be exactly as stated: one clock clk; reset rst_n asynchronous, active-low.

Function
REQ-004 SHALL translate a mapper-level request into the full physical JEDEC command sequence on the flash bus.
REQ-005 Program sequence SHALL be 4 bus cycles: AA@000555, 55@0002AA, A0@000555, req_dat@req_addr.
REQ-006 Erase sequence SHALL be 6 bus cycles: AA@000555, 55@0002AA, 80@000555, AA@000555, 55@0002AA, 30@req_addr.
REQ-007 Each bus cycle SHALL be SETUP (T_SU cycles, fla_ce_n=0, fla_we_n=1, addr/dat valid), PULSE (T_WP cycles, fla_we_n=0), HOLD (T_HLD cycles, fla_we_n=1, addr/dat held); fla_addr/fla_dat SHALL NOT change while fla_ce_n=0 within one bus cycle.
REQ-008 State machine SHALL be IDLE -> SETUP -> PULSE -> HOLD -> (SETUP of next cycle | WAIT after last cycle) -> IDLE.
REQ-009 WAIT SHALL last T_PROG cycles (program) or T_ERS cycles (erase) with fla_ce_n=1, fla_we_n=1.
REQ-010 busy SHALL rise the cycle after an accepted request and fall in the same cycle done pulses, at WAIT expiry.
REQ-011 req_addr/req_dat SHALL be latched on acceptance; later input changes SHALL NOT affect the sequence.
REQ-012 Requests while busy=1 SHALL be ignored, without queuing.
REQ-013 req and req_erase together in IDLE: erase SHALL win when erase is compiled in, otherwise program.
REQ-014 Down-counters SHALL be 11 bits wide; a parameter value of 0 SHALL be treated as 1.
REQ-015 Program total latency from req to done SHALL be 4*(T_SU+T_WP+T_HLD)+T_PROG+1 cycles; erase uses 6 bus cycles and T_ERS.

Reset
REQ-016 rst_n low SHALL immediately force IDLE, busy=0, done=0, fla_ce_n=1, fla_we_n=1, fla_addr=0, fla_dat=0, including mid-sequence.
REQ-017 After reset release, the first accepted request SHALL restart from bus cycle 0; there SHALL be no resumption.

Configuration
REQ-018 Macro MAP_FLA_SEQ_ERASE_EN SHALL gate erase support.
REQ-019 With MAP_FLA_SEQ_ERASE_EN defined, req_erase SHALL run the 6-cycle erase per REQ-006.
REQ-020 Without MAP_FLA_SEQ_ERASE_EN, req_erase SHALL be ignored (no busy, no bus activity), T_ERS logic SHALL be absent, and the counter SHALL be 5 bits.

Structure
REQ-021 Command bytes (AA, 55, A0, 80, 30) and unlock addresses (000555, 0002AA) SHALL live in the shared defs package for reuse by mapper decoders.
REQ-022 One sub-module, map_fla_buscyc, SHALL implement the SETUP/PULSE/HOLD timing of a single bus cycle with start/finish handshake; the top SHALL sequence cycle index and WAIT.

Verification
REQ-023 Program: req, req_addr=012345, req_dat=5A, defaults -> 4 WE pulses of 3 cycles each, writes AA@555, 55@2AA, A0@555, 5A@012345; done at cycle 45; busy high cycles 1..44.
REQ-024 Erase (macro on): req_erase, req_addr=040000, T_ERS=8 -> 6 pulses ending 30@040000; done at cycle 6*7+8+1=51.
REQ-025 Erase (macro off): req_erase -> busy stays 0, fla_ce_n stays 1 for 100 cycles.
REQ-026 Busy collision: second req at cycle 10 with req_dat=FF -> ignored, final data write 5A, exactly one done.
REQ-027 Reset mid-PULSE of bus cycle 2 -> fla_we_n=1, fla_ce_n=1 asynchronously; the next req emits the full 4-cycle sequence from AA@555.
REQ-028 Simultaneous req+req_erase (macro on) -> 6-cycle erase sequence, single done.
